// File: rtl/rram_pkg.sv
// Shared types and default sizes for the RRAM array controller slice.
package rram_pkg;

    localparam int WORDS_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int FORM_W_DEF = 13;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_FORM  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Operation currently owned by the sequencer
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_FORM  = 2'd3
    } op_e;

endpackage

// File: rtl/rram_wrap_counter.sv
// Load/step counter that wraps N-1 -> 0 by explicit compare, so it works
// for any N, including non-power-of-2 values.
module rram_wrap_counter
    import rram_pkg::*;
#(
    parameter int             N       = WORDS_DEF,
    parameter int             W       = ADDR_W_DEF,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load beats step, step wraps at N-1
    always_comb begin
        // NOTE: default-assign first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (step) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rram_seq_counter.sv
// Operation sequencer for the RRAM array controller: runs write/read bursts
// and forming pulses on request from control, and keeps the data_register
// readout address for the external read port.
module rram_seq_counter
    import rram_pkg::*;
#(
    parameter int WORDS  = WORDS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FORM_W = FORM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              re,
    input  logic              forming,
    input  logic [FORM_W-1:0] form_len,
    input  logic              rd_start,
    input  logic              rd_step,
    output logic [ADDR_W-1:0] cache_add,
    output logic [ADDR_W-1:0] register_add,
    output logic              write_count_flag,
    output logic              cache_count_flag,
    output logic              forming_count_flag,
    output logic              mode_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [FORM_W-1:0] form_len_q, form_len_d;
    logic [FORM_W-1:0] form_cnt_q, form_cnt_d;
    logic              wflag_q, wflag_d;
    logic              cflag_q, cflag_d;
    logic              fflag_q, fflag_d;
    logic              mode_err_q, mode_err_d;

    logic              multi_req;
    logic              active_req;
    logic              cache_step;
    logic              cache_load;
    logic [ADDR_W-1:0] cache_load_val;

    assign multi_req = ({1'b0, we} + {1'b0, re} + {1'b0, forming}) > 2'd1;

    // Request line belonging to the operation in progress
    always_comb begin
        active_req = 1'b0;
        case (op_q)
            OP_WRITE: active_req = we;
            OP_READ:  active_req = re;
            OP_FORM:  active_req = forming;
            default:  active_req = 1'b0;
        endcase
    end

    // Next-state, forming counter, flags and sticky error
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        form_len_d = form_len_q;
        form_cnt_d = form_cnt_q;
        mode_err_d = mode_err_q | multi_req;

        case (state_q)
            S_IDLE: begin
                form_cnt_d = '0;
                if (forming) begin
                    state_d    = S_FORM;
                    op_d       = OP_FORM;
                    form_len_d = (form_len == '0) ? FORM_W'(1) : form_len;
                end else if (we) begin
                    state_d = S_WRITE;
                    op_d    = OP_WRITE;
                end else if (re) begin
                    state_d = S_READ;
                    op_d    = OP_READ;
                end
            end
            S_WRITE, S_READ: begin
                if (!active_req) begin
                    state_d = S_IDLE;
                    op_d    = OP_NONE;
                end else if (cache_add == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_FORM: begin
                if (!active_req) begin
                    state_d    = S_IDLE;
                    op_d       = OP_NONE;
                    form_cnt_d = '0;
                end else if (form_cnt_q == form_len_q - FORM_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    form_cnt_d = form_cnt_q + FORM_W'(1);
                end
            end
            S_DONE: begin
                if (!active_req) begin
                    state_d    = S_IDLE;
                    op_d       = OP_NONE;
                    form_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                op_d    = OP_NONE;
            end
        endcase

        if (!en) begin
            state_d    = S_IDLE;
            op_d       = OP_NONE;
            form_cnt_d = '0;
            mode_err_d = 1'b0;
        end

        wflag_d = (state_d == S_DONE) && (op_d == OP_WRITE);
        cflag_d = (state_d == S_DONE) && (op_d == OP_READ);
        fflag_d = (state_d == S_DONE) && (op_d == OP_FORM);
    end

    // Burst address: step while a burst continues, otherwise park at 0 or WORDS-1 in DONE
    always_comb begin
        cache_step     = en && (state_q == S_WRITE || state_q == S_READ) && (state_d == state_q);
        cache_load     = !cache_step;
        cache_load_val = (state_d == S_DONE) ? LAST : '0;
    end

    rram_wrap_counter #(
        .N       (WORDS),
        .W       (ADDR_W),
        .RST_VAL ('0)
    ) u_cache_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cache_load),
        .load_val (cache_load_val),
        .step     (cache_step),
        .count    (cache_add)
    );

    rram_wrap_counter #(
        .N       (WORDS),
        .W       (ADDR_W),
        .RST_VAL (LAST)
    ) u_reg_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_start || !en),
        .load_val (LAST),
        .step     (rd_step),
        .count    (register_add)
    );

    // Sequencer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NONE;
            form_len_q <= '0;
            form_cnt_q <= '0;
            wflag_q    <= 1'b0;
            cflag_q    <= 1'b0;
            fflag_q    <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            op_q       <= op_d;
            form_len_q <= form_len_d;
            form_cnt_q <= form_cnt_d;
            wflag_q    <= wflag_d;
            cflag_q    <= cflag_d;
            fflag_q    <= fflag_d;
            mode_err_q <= mode_err_d;
        end
    end

    assign write_count_flag   = wflag_q;
    assign cache_count_flag   = cflag_q;
    assign forming_count_flag = fflag_q;
    assign mode_err           = mode_err_q;
    assign busy               = (state_q != S_IDLE);

endmodule
